// File: rtl/vx_tcu_drl_align_acc.sv
// ============================================================================
//  Module   : vx_tcu_drl_align_acc
//  Brief    : Two-stage align/negate + sum pipeline for tensor-core dot
//             products. S1 aligns each multiplier term to the common max
//             exponent (float) or sign-extends it (integer), applies the term
//             masks and registers the terms. S2 adds all terms into one
//             two's-complement sum. Valid/ready handshake on both sides.
//  Options  : define TCU_DRL_STICKY_EN to build the shifted-out sticky logic;
//             without it sticky_out is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vx_tcu_drl_align_acc #(
  parameter  int N   = 2,
  parameter  int TCK = 2 * N,
  localparam int SW  = 31 + $clog2(TCK + 1) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  output logic                 ready_in,
  input  logic [3:0]           fmt_s,
  input  logic [TCK:0][24:0]   y,
  input  logic [TCK:0][7:0]    shift,
  input  logic [7:0]           exp_max,
  input  logic [TCK:0]         term_mask,
  output logic                 valid_out,
  input  logic                 ready_out,
  output logic [SW-1:0]        sum_out,
  output logic                 sticky_out,
  output logic [7:0]           exp_out,
  output logic [3:0]           fmt_out
);

  logic                  r_s1_valid;
  logic [TCK:0][SW-1:0]  r_term;
  logic [7:0]            r_s1_exp;
  logic [3:0]            r_s1_fmt;
  logic [TCK:0][SW-1:0]  w_term;
  logic [SW-1:0]         w_sum;
  logic                  w_s2_ready;
  logic                  w_is_int;

  assign w_is_int   = fmt_s[3];
  assign w_s2_ready = !valid_out || ready_out;
  // S1 may fill whenever it is empty or its beat moves into S2 this cycle.
  assign ready_in   = !r_s1_valid || w_s2_ready;

`ifdef TCU_DRL_STICKY_EN
  logic [TCK:0] w_sticky_term;
  logic         r_s1_sticky;
`endif

  // Per-term alignment: float terms are shifted right to the max exponent
  // and negated on sign; integer terms are plain sign extensions.
  for (genvar k = 0; k <= TCK; k++) begin : g_term
    logic [30:0]   w_field;
    logic [30:0]   w_aligned;
    logic [SW-1:0] w_mag_ext;
    logic [SW-1:0] w_float_term;
    logic [SW-1:0] w_int_term;

    assign w_field      = {y[k][23:0], 7'b0};
    // Shifts of 31 or more push every bit out of the 31-bit field.
    assign w_aligned    = (shift[k] >= 8'd31) ? 31'd0 : (w_field >> shift[k]);
    assign w_mag_ext    = {{(SW-31){1'b0}}, w_aligned};
    assign w_float_term = y[k][24] ? (~w_mag_ext + 1'b1) : w_mag_ext;
    assign w_int_term   = {{(SW-25){y[k][24]}}, y[k]};
    assign w_term[k]    = !term_mask[k] ? '0 :
                          (w_is_int ? w_int_term : w_float_term);

`ifdef TCU_DRL_STICKY_EN
    logic w_lost;
    // Low 'shift' bits of the field are the ones that fall off the right end.
    assign w_lost = (shift[k] >= 8'd31) ? (w_field != 31'd0) :
                    ((w_field & ~(31'h7FFF_FFFF << shift[k])) != 31'd0);
    assign w_sticky_term[k] = term_mask[k] && !w_is_int && w_lost;
`endif
  end

  // Stage 1 register: capture aligned terms and side-band on an accepted beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_term     <= '0;
      r_s1_exp   <= '0;
      r_s1_fmt   <= '0;
    end else if (ready_in) begin
      r_s1_valid <= valid_in;
      if (valid_in) begin
        r_term   <= w_term;
        r_s1_exp <= exp_max;
        r_s1_fmt <= fmt_s;
      end
    end
  end

  // Stage 2 adder: width SW leaves headroom for TCK+1 full-scale terms.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k <= TCK; k++) begin
      w_sum = w_sum + r_term[k];
    end
  end

  // Stage 2 register: output beat is held until downstream takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out <= 1'b0;
      sum_out   <= '0;
      exp_out   <= '0;
      fmt_out   <= '0;
    end else if (w_s2_ready) begin
      valid_out <= r_s1_valid;
      if (r_s1_valid) begin
        sum_out <= w_sum;
        exp_out <= r_s1_exp;
        fmt_out <= r_s1_fmt;
      end
    end
  end

`ifdef TCU_DRL_STICKY_EN
  // Sticky travels alongside the terms through both stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_sticky <= 1'b0;
    end else if (ready_in && valid_in) begin
      r_s1_sticky <= |w_sticky_term;
    end
  end

  // Sticky output register, loaded together with sum_out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_out <= 1'b0;
    end else if (w_s2_ready && r_s1_valid) begin
      sticky_out <= r_s1_sticky;
    end
  end
`else
  assign sticky_out = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vx_tcu_drl_align_acc.sv
// ============================================================================
//  Module   : tb_vx_tcu_drl_align_acc
//  Brief    : Directed + randomised bench for vx_tcu_drl_align_acc with an
//             expected-result queue filled on input acceptance and drained by
//             an output monitor.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vx_tcu_drl_align_acc;

  localparam int N   = 2;
  localparam int TCK = 2 * N;
  localparam int SW  = 35;
`ifdef TCU_DRL_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  typedef logic [TCK:0][24:0] yv_t;
  typedef logic [TCK:0][7:0]  sv_t;
  typedef logic [TCK:0]       mv_t;
  typedef struct packed {
    logic [SW-1:0] sum;
    logic          sticky;
    logic [7:0]    exp;
    logic [3:0]    fmt;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          valid_in = 1'b0;
  logic          ready_in;
  logic [3:0]    fmt_s = '0;
  yv_t           y = '0;
  sv_t           shift = '0;
  logic [7:0]    exp_max = '0;
  mv_t           term_mask = '0;
  logic          valid_out;
  logic          ready_out = 1'b1;
  logic [SW-1:0] sum_out;
  logic          sticky_out;
  logic [7:0]    exp_out;
  logic [3:0]    fmt_out;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   outputs    = 0;
  exp_t mon_e;

  vx_tcu_drl_align_acc #(.N(N), .TCK(TCK)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .fmt_s(fmt_s), .y(y), .shift(shift), .exp_max(exp_max),
    .term_mask(term_mask), .valid_out(valid_out), .ready_out(ready_out),
    .sum_out(sum_out), .sticky_out(sticky_out), .exp_out(exp_out),
    .fmt_out(fmt_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [SW-1:0] s, input logic st,
                              input logic [7:0] e, input logic [3:0] f);
    exp_t r;
    r.sum = s; r.sticky = st; r.exp = e; r.fmt = f;
    return r;
  endfunction

  // Reference: exact arithmetic on 64-bit integers, then wrap to SW bits.
  function automatic exp_t model(input logic [3:0] f, input yv_t yy, input sv_t sh,
                                 input logic [7:0] e, input mv_t m);
    longint          acc;
    longint unsigned full, al, lost;
    logic            st;
    exp_t            r;
    acc = 0; st = 1'b0;
    for (int k = 0; k <= TCK; k++) begin
      if (m[k]) begin
        if (f[3]) begin
          acc += longint'($signed(yy[k]));
        end else begin
          full = longint'(yy[k][23:0]) * 128;
          al   = (sh[k] >= 8'd63) ? 64'd0 : (full >> sh[k]);
          lost = (sh[k] >= 8'd63) ? full : (full - (al << sh[k]));
          if (yy[k][24]) acc -= longint'(al); else acc += longint'(al);
          if (lost != 0) st = 1'b1;
        end
      end
    end
    r.sum = acc[SW-1:0]; r.sticky = st & STK; r.exp = e; r.fmt = f;
    return r;
  endfunction

  // Present a beat from posedge+1; push its expectation when it is accepted.
  task automatic send(input logic [3:0] f, input yv_t yy, input sv_t sh,
                      input logic [7:0] e, input mv_t m, input exp_t ex,
                      output int stalls);
    bit ok;
    fmt_s = f; y = yy; shift = sh; exp_max = e; term_mask = m; valid_in = 1'b1;
    stalls = 0; ok = 1'b0;
    while (!ok && stalls <= 50) begin
      @(negedge clk);
      if (ready_in) ok = 1'b1;
      else begin stalls++; @(posedge clk); #1; end
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
    else begin
      q.push_back(ex);
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin @(posedge clk); n++; end
    #1;
    check("drain_queue_empty", 64'(q.size()), 64'd0);
  endtask

  // Output monitor: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clk) begin
    if (!reset && valid_out && ready_out) begin
      if (q.size() == 0) begin
        check("unexpected_output", 64'd1, 64'd0);
      end else begin
        mon_e = q.pop_front();
        outputs++;
        check("sum_out",    64'(sum_out),    64'(mon_e.sum));
        check("sticky_out", 64'(sticky_out), 64'(mon_e.sticky));
        check("exp_out",    64'(exp_out),    64'(mon_e.exp));
        check("fmt_out",    64'(fmt_out),    64'(mon_e.fmt));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   st, tot, base;
    yv_t  ry;
    sv_t  rs;
    mv_t  rm;
    logic [3:0] rf;
    logic [7:0] re;
    exp_t ea;

    // Reset state, asserted asynchronously before any clock edge.
    #2 reset = 1'b1;
    #1;
    check("rst_valid_out",  64'(valid_out),  64'd0);
    check("rst_sum_out",    64'(sum_out),    64'd0);
    check("rst_sticky_out", 64'(sticky_out), 64'd0);
    check("rst_exp_out",    64'(exp_out),    64'd0);
    check("rst_fmt_out",    64'(fmt_out),    64'd0);
    check("rst_ready_in",   64'(ready_in),   64'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("post_rst_ready_in", 64'(ready_in), 64'd1);

    // +1.0 in every term: 5 * 2^30.
    send(4'h1, {5{25'h0800000}}, {5{8'h00}}, 8'h8F, 5'b11111,
         mk(35'h1_4000_0000, 1'b0, 8'h8F, 4'h1), st);
    drain();
    // +1.0 and -1.0 cancel, remaining terms masked.
    send(4'h2, {25'h1FFFFFF, 25'h0ABCDEF, 25'h0123456, 25'h1800000, 25'h0800000},
         {5{8'h00}}, 8'h10, 5'b00011, mk(35'h0, 1'b0, 8'h10, 4'h2), st);
    drain();
    // Lone LSB shifted off the end: zero sum, sticky when built.
    send(4'h1, {{4{25'h0FFFFFF}}, 25'h0000001}, {{4{8'h00}}, 8'h08}, 8'h20, 5'b00001,
         mk(35'h0, STK, 8'h20, 4'h1), st);
    drain();
    // Shift of 31 or more zeros a full magnitude.
    send(4'h1, {{4{25'h0}}, 25'h0FFFFFF}, {{4{8'h00}}, 8'd31}, 8'h21, 5'b00001,
         mk(35'h0, STK, 8'h21, 4'h1), st);
    drain();
    // Integer -1 in all terms with shift ignored.
    send(4'h8, {5{25'h1FFFFFF}}, {5{8'hFF}}, 8'h33, 5'b11111,
         mk(35'h7_FFFF_FFFB, 1'b0, 8'h33, 4'h8), st);
    drain();

    // Back-to-back streaming with random terms: no bubbles expected.
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k <= TCK; k++) begin
        ry[k] = 25'($urandom);
        rs[k] = 8'($urandom_range(0, 40));
      end
      rm = 5'($urandom);
      rf = (i % 2 == 0) ? 4'h1 : 4'h9;
      re = 8'($urandom);
      send(rf, ry, rs, re, rm, model(rf, ry, rs, re, rm), st);
      tot += st;
    end
    check("stream_stall_cycles", 64'(tot), 64'd0);
    drain();

    // Backpressure: three beats while the output is blocked.
    base = outputs;
    ready_out = 1'b0;
    ea = mk(35'h0_4000_0000, 1'b0, 8'hA1, 4'h1);
    send(4'h1, {{4{25'h0}}, 25'h0800000}, '0, 8'hA1, 5'b00001, ea, st);
    send(4'h1, {{3{25'h0}}, 25'h0800000, 25'h0800000}, '0, 8'hA2, 5'b00011,
         mk(35'h0_8000_0000, 1'b0, 8'hA2, 4'h1), st);
    fmt_s = 4'h8; y = {5{25'h0000003}}; shift = '0; exp_max = 8'hA3;
    term_mask = 5'b11111; valid_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bp_ready_in_low",  64'(ready_in),  64'd0);
      check("bp_valid_held",    64'(valid_out), 64'd1);
      check("bp_sum_held",      64'(sum_out),   64'(ea.sum));
      @(posedge clk); #1;
    end
    ready_out = 1'b1;
    send(4'h8, {5{25'h0000003}}, '0, 8'hA3, 5'b11111,
         mk(35'd15, 1'b0, 8'hA3, 4'h8), st);
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("bp_output_count", 64'(outputs - base), 64'd3);

    // Reset with both stages full: outputs clear at once, nothing stale later.
    ready_out = 1'b0;
    send(4'h1, {5{25'h0800000}}, '0, 8'h55, 5'b11111,
         mk(35'h1_4000_0000, 1'b0, 8'h55, 4'h1), st);
    send(4'h1, {5{25'h0800000}}, '0, 8'h56, 5'b11111,
         mk(35'h1_4000_0000, 1'b0, 8'h56, 4'h1), st);
    check("mid_valid_before_rst", 64'(valid_out), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid_out", 64'(valid_out), 64'd0);
    check("mid_rst_sum_out",   64'(sum_out),   64'd0);
    check("mid_rst_exp_out",   64'(exp_out),   64'd0);
    check("mid_rst_ready_in",  64'(ready_in),  64'd1);
    q.delete();
    ready_out = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    base = outputs;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_no_stale", 64'(outputs - base), 64'd0);
    check("post_rst_valid_out", 64'(valid_out), 64'd0);

    // Pipeline still works after the mid-flight reset.
    send(4'h9, {5{25'h1FFFFFE}}, '0, 8'h77, 5'b10101,
         mk(35'h7_FFFF_FFFA, 1'b0, 8'h77, 4'h9), st);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vx_tcu_drl_align_acc.md
VX_TCU_DRL_ALIGN_ACC -- requirements
Module: VX_tcu_drl_align_acc

Interface
REQ-001 The block SHALL have parameter N, default 2, meaning dot-product lanes per row.
REQ-002 The block SHALL have parameter TCK, default 2*N, meaning product terms per cycle, excluding the C term.
REQ-003 The block SHALL have localparam SW = 31 + $clog2(TCK+1) + 1, meaning the signed sum width.
REQ-004 Port clk, input, 1, is the sole clock; all state is rising-edge.
REQ-005 Port reset, input, 1, is the reset: asynchronous, active-high.
REQ-006 Port valid_in, input, 1, qualifies the input beat.
REQ-007 Port ready_in, output, 1, indicates the block accepts the beat this cycle.
REQ-008 Port fmt_s, input, 4, is the format; fmt_s[3]=1 means integer, else float.
REQ-009 Port y, input, (TCK+1)x25, carries the multiplier-stage terms; index TCK is the C term.
REQ-010 Port shift, input, (TCK+1)x8, gives the per-term right-shift to the max exponent.
REQ-011 Port exp_max, input, 8, is the common exponent, passed through unmodified.
REQ-012 Port term_mask, input, TCK+1, enables each term; 0 forces that term to zero.
REQ-013 Port valid_out, output, 1, qualifies the output beat.
REQ-014 Port ready_out, input, 1, is downstream backpressure.
REQ-015 Port sum_out, output, SW, is the two's-complement aligned sum.
REQ-016 Port sticky_out, output, 1, is the OR of all shifted-out nonzero bits (see Configuration).
REQ-017 Port exp_out, output, 8, carries exp_max delayed with its beat.
REQ-018 Port fmt_out, output, 4, carries fmt_s delayed with its beat.

Function
REQ-019 The block SHALL be a two-stage pipeline: S1 = align and negate, S2 = sum; latency SHALL be 2 cycles with no stall.
REQ-020 A beat SHALL transfer at each stage boundary only when valid and ready are both 1; ready_in = !s1_valid | s2_ready; s2_ready = !valid_out | ready_out.
REQ-021 Stalled stages SHALL hold all data bits stable; valid_out SHALL NOT drop until accepted.
REQ-022 Float term: sign = y[k][24], magnitude = y[k][23:0], placed as {mag,7'b0} in a 31-bit field, logically right-shifted by shift[k].
REQ-023 Float term: shift[k] >= 31 SHALL yield zero aligned magnitude.
REQ-024 Float term: the aligned magnitude SHALL be zero-extended to SW and negated when the sign is 1.
REQ-025 Integer term: y[k] SHALL be sign-extended from 25 bits to SW, with shift ignored and no sticky contribution.
REQ-026 S1 SHALL register all TCK+1 aligned SW-bit terms and the masks applied; S2 SHALL add them modulo 2^SW, with no overflow possible by width.
REQ-027 exp_out and fmt_out SHALL travel with their beat through both stages.
REQ-028 Simultaneous S2 drain and S1 fill in the same cycle SHALL sustain one beat per cycle with no bubble.

Reset
REQ-029 On reset assertion, valid_out, the internal s1_valid, sum_out, sticky_out, exp_out and fmt_out SHALL go to 0 immediately, regardless of clk.
REQ-030 ready_in SHALL read 1 during and after reset.
REQ-031 A beat in flight at reset SHALL be discarded and never emitted.

Configuration
REQ-032 With macro TCU_DRL_STICKY_EN defined, S1 SHALL compute a per-term sticky (any 1 bits shifted out, or a nonzero magnitude with shift >= 31) for unmasked float terms, OR them, and carry the result to sticky_out.
REQ-033 Without TCU_DRL_STICKY_EN, sticky_out SHALL be constant 0 and no sticky logic SHALL be built.

Verification
REQ-034 FP16: N=2, all masks 1, all shifts 0, y[k] = 0x0800000 (+1.0 aligned), 5 terms -> sum_out = 5*0x40000000 after 2 cycles; sticky_out = 0.
REQ-035 Float cancel: y[0] = 0x0800000, y[1] = 0x1800000, others masked -> sum_out = 0.
REQ-036 Shift/sticky: y[0] = 0x0000001, shift[0] = 8, others masked -> sum_out = 0; sticky_out = 1 with the macro, 0 without.
REQ-037 INT8: fmt_s = I8, y[k] = 25'h1FFFFFF (-1) for all 5 terms, shift = 0xFF -> sum_out = -5, shift ignored.
REQ-038 Backpressure: ready_out = 0 for 4 cycles during 3 back-to-back beats -> ready_in drops after 2 beats are held, all 3 sums emerge in order, none is duplicated.
REQ-039 Reset mid-flight: assert reset with both stages valid -> valid_out = 0 in the same cycle; no stale beat appears after release.
